// File: rtl/ddr3_port_arbiter_pkg.sv
// Shared definitions for the DDR3MI port arbiter: FSM state encoding,
// DDR3MI command codes, burst-length field width and a saturating
// increment used by the optional performance counters.
package ddr3_port_arbiter_pkg;

    localparam int          BURST_W   = 6;
    localparam logic [2:0]  CMD_WRITE = 3'b000;
    localparam logic [2:0]  CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } arb_state_e;

    // 32-bit counter step that holds at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ddr3_rr_picker.sv
// Rotating-priority picker: returns the first asserted request at or after
// ptr_i (wrapping), as both a one-hot vector and an index.
module ddr3_rr_picker
    import ddr3_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               any_o,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan requesters starting from the pointer; the first one found wins.
    always_comb begin
        logic [IDX_W-1:0] j;
        j      = '0;
        any_o  = 1'b0;
        pick_o = '0;
        idx_o  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[j]) begin
                any_o     = 1'b1;
                pick_o[j] = 1'b1;
                idx_o     = j;
            end
        end
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Round-robin arbiter sharing one DDR3MI user port between NUM_REQ DMA
// requesters. A grant covers a whole transaction (command plus all beats).
// Optional feature macro: DDR_ARB_PERF_CNT_EN builds the per-requester
// transaction and wait counters; without it O_perf_* are tied to zero.
module ddr3_port_arbiter
    import ddr3_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                             I_dma_clk,
    input  logic                             I_rst_n,
    input  logic                             I_init_calib_complete,
    input  logic [NUM_REQ-1:0]               I_req,
    input  logic [NUM_REQ-1:0]               I_req_cmd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    I_req_addr,
    input  logic [NUM_REQ*BURST_W-1:0]       I_req_burst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    I_req_wr_data,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  I_req_wr_mask,
    input  logic [NUM_REQ-1:0]               I_req_wr_valid,
    output logic [NUM_REQ-1:0]               O_gnt,
    output logic [NUM_REQ-1:0]               O_req_wr_ack,
    output logic [NUM_REQ-1:0]               O_req_rd_valid,
    output logic [DATA_WIDTH-1:0]            O_rd_data,
    output logic                             O_err,
    input  logic                             I_cmd_ready,
    output logic [2:0]                       O_cmd,
    output logic                             O_cmd_en,
    output logic [ADDR_WIDTH-1:0]            O_addr,
    output logic [BURST_W-1:0]               O_app_burst_number,
    input  logic                             I_wr_data_rdy,
    output logic                             O_wr_data_en,
    output logic                             O_wr_data_end,
    output logic [DATA_WIDTH-1:0]            O_wr_data,
    output logic [DATA_WIDTH/8-1:0]          O_wr_data_mask,
    input  logic                             I_rd_data_valid,
    input  logic                             I_rd_data_end,
    input  logic [DATA_WIDTH-1:0]            I_rd_data,
    output logic [NUM_REQ*32-1:0]            O_perf_txn,
    output logic [NUM_REQ*32-1:0]            O_perf_wait
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int MASK_W = DATA_WIDTH / 8;

    // Per-requester views of the flattened input buses.
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [BURST_W-1:0]    burst_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [MASK_W-1:0]     wmask_arr [NUM_REQ];

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = I_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign burst_arr[gi] = I_req_burst[gi*BURST_W +: BURST_W];
        assign wdata_arr[gi] = I_req_wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign wmask_arr[gi] = I_req_wr_mask[gi*MASK_W +: MASK_W];
    end

    arb_state_e            state_q,    state_d;
    logic [NUM_REQ-1:0]    gnt_q,      gnt_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic                  cmd_q,      cmd_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [BURST_W-1:0]    burst_q,    burst_d;
    logic [BURST_W-1:0]    cnt_q,      cnt_d;
    logic [IDX_W-1:0]      rr_ptr_q,   rr_ptr_d;
    logic                  err_q,      err_d;
    logic [NUM_REQ-1:0]    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;

    logic                  pick_any;
    logic [NUM_REQ-1:0]    pick;
    logic [IDX_W-1:0]      pick_idx;
    logic                  last_beat;
    logic                  txn_done;

    // The end-of-read strobe carries no information the beat counter lacks.
    logic unused_rd_data_end;
    assign unused_rd_data_end = I_rd_data_end;

    ddr3_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i  (I_req),
        .ptr_i  (rr_ptr_q),
        .any_o  (pick_any),
        .pick_o (pick),
        .idx_o  (pick_idx)
    );

    // State register and all registered datapath; everything clears on reset.
    always_ff @(posedge I_dma_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            idx_q      <= '0;
            cmd_q      <= 1'b0;
            addr_q     <= '0;
            burst_q    <= '0;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Next-state logic and the combinational DDR3MI handshake outputs.
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        idx_d          = idx_q;
        cmd_d          = cmd_q;
        addr_d         = addr_q;
        burst_d        = burst_q;
        cnt_d          = cnt_q;
        rr_ptr_d       = rr_ptr_q;
        err_d          = err_q;
        rd_valid_d     = '0;
        rd_data_d      = I_rd_data;
        O_cmd_en       = 1'b0;
        O_cmd          = 3'b000;
        O_wr_data_en   = 1'b0;
        O_wr_data_end  = 1'b0;
        O_req_wr_ack   = '0;
        O_wr_data      = '0;
        O_wr_data_mask = '0;
        txn_done       = 1'b0;
        last_beat      = (cnt_q == burst_q);

        // Read data with no read transaction to deliver it to is lost.
        if (I_rd_data_valid && (state_q != ST_RDATA)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (I_init_calib_complete && pick_any) begin
                    gnt_d    = pick;
                    idx_d    = pick_idx;
                    cmd_d    = I_req_cmd[pick_idx];
                    addr_d   = addr_arr[pick_idx];
                    burst_d  = burst_arr[pick_idx];
                    rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d  = ST_CMD;
                end
            end
            ST_CMD: begin
                O_cmd_en = I_cmd_ready;
                O_cmd    = cmd_q ? CMD_READ : CMD_WRITE;
                if (I_cmd_ready) begin
                    cnt_d   = '0;
                    state_d = cmd_q ? ST_RDATA : ST_WDATA;
                end
            end
            ST_WDATA: begin
                O_wr_data      = wdata_arr[idx_q];
                O_wr_data_mask = wmask_arr[idx_q];
                O_wr_data_en   = I_wr_data_rdy & I_req_wr_valid[idx_q];
                O_req_wr_ack   = O_wr_data_en ? gnt_q : '0;
                O_wr_data_end  = O_wr_data_en & last_beat;
                if (O_wr_data_en) begin
                    if (last_beat) begin
                        gnt_d    = '0;
                        txn_done = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RDATA: begin
                rd_valid_d = I_rd_data_valid ? gnt_q : '0;
                if (I_rd_data_valid) begin
                    if (last_beat) begin
                        gnt_d    = '0;
                        txn_done = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign O_gnt              = gnt_q;
    assign O_req_rd_valid     = rd_valid_q;
    assign O_rd_data          = rd_data_q;
    assign O_err              = err_q;
    assign O_addr             = addr_q;
    assign O_app_burst_number = burst_q;

`ifdef DDR_ARB_PERF_CNT_EN
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
        logic [31:0] txn_cnt_q;
        logic [31:0] wait_cnt_q;

        // Completed transactions and unserved request cycles for requester gi.
        always_ff @(posedge I_dma_clk or negedge I_rst_n) begin
            if (!I_rst_n) begin
                txn_cnt_q  <= '0;
                wait_cnt_q <= '0;
            end else begin
                if (txn_done && gnt_q[gi]) begin
                    txn_cnt_q <= sat_inc(txn_cnt_q);
                end
                if (I_req[gi] && !gnt_q[gi]) begin
                    wait_cnt_q <= sat_inc(wait_cnt_q);
                end
            end
        end

        assign O_perf_txn[gi*32 +: 32]  = txn_cnt_q;
        assign O_perf_wait[gi*32 +: 32] = wait_cnt_q;
    end
`else
    logic unused_txn_done;
    assign unused_txn_done = txn_done;
    assign O_perf_txn      = '0;
    assign O_perf_wait     = '0;
`endif

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Randomised bench for ddr3_port_arbiter: requesters issue random
// read/write transactions, the DDR3MI side toggles its ready/valid
// handshakes at random, and a transaction-level reference model predicts
// every output cycle by cycle.
module tb_ddr3_port_arbiter;

    localparam int N    = 2;
    localparam int AW   = 28;
    localparam int DW   = 128;
    localparam int MW   = DW / 8;
    localparam int NCYC = 4000;

    logic              clk = 1'b0;
    logic              I_rst_n;
    logic              I_init_calib_complete;
    logic [N-1:0]      I_req, I_req_cmd, I_req_wr_valid;
    logic [N*AW-1:0]   I_req_addr;
    logic [N*6-1:0]    I_req_burst;
    logic [N*DW-1:0]   I_req_wr_data;
    logic [N*MW-1:0]   I_req_wr_mask;
    logic [N-1:0]      O_gnt, O_req_wr_ack, O_req_rd_valid;
    logic [DW-1:0]     O_rd_data, O_wr_data, I_rd_data;
    logic              O_err, I_cmd_ready, O_cmd_en, I_wr_data_rdy;
    logic              O_wr_data_en, O_wr_data_end, I_rd_data_valid, I_rd_data_end;
    logic [2:0]        O_cmd;
    logic [AW-1:0]     O_addr;
    logic [5:0]        O_app_burst_number;
    logic [MW-1:0]     O_wr_data_mask;
    logic [N*32-1:0]   O_perf_txn, O_perf_wait;

    always #5 clk = ~clk;

    ddr3_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .I_dma_clk(clk), .I_rst_n(I_rst_n), .I_init_calib_complete(I_init_calib_complete),
        .I_req(I_req), .I_req_cmd(I_req_cmd), .I_req_addr(I_req_addr), .I_req_burst(I_req_burst),
        .I_req_wr_data(I_req_wr_data), .I_req_wr_mask(I_req_wr_mask), .I_req_wr_valid(I_req_wr_valid),
        .O_gnt(O_gnt), .O_req_wr_ack(O_req_wr_ack), .O_req_rd_valid(O_req_rd_valid),
        .O_rd_data(O_rd_data), .O_err(O_err), .I_cmd_ready(I_cmd_ready), .O_cmd(O_cmd),
        .O_cmd_en(O_cmd_en), .O_addr(O_addr), .O_app_burst_number(O_app_burst_number),
        .I_wr_data_rdy(I_wr_data_rdy), .O_wr_data_en(O_wr_data_en), .O_wr_data_end(O_wr_data_end),
        .O_wr_data(O_wr_data), .O_wr_data_mask(O_wr_data_mask), .I_rd_data_valid(I_rd_data_valid),
        .I_rd_data_end(I_rd_data_end), .I_rd_data(I_rd_data),
        .O_perf_txn(O_perf_txn), .O_perf_wait(O_perf_wait)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Requester-side state (what each DMA client is currently asking for).
    bit           pend[N];
    bit           r_cmd[N];
    logic [AW-1:0] r_addr[N];
    logic [5:0]   r_burst[N];
    logic [127:0] r_base[N];
    int           r_wbeat[N];
    bit           r_gnt_seen[N];

    // Transaction-level reference model.
    int           m_owner;   // -1 when the port is free
    int           m_rr;
    int           m_phase;   // 0 free, 1 command pending, 2 data beats
    bit           m_cmd;
    logic [AW-1:0] m_addr;
    logic [5:0]   m_burst;
    logic [127:0] m_base;
    int           m_beat;
    int           m_left;
    bit           m_err;
    logic [N-1:0] m_rdv;
    logic [DW-1:0] m_rdd;
    longint       m_ptxn[N];
    longint       m_pwait[N];
    int           n_txn = 0;
    bit           rst_done = 0;
    bit           err_injected = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [127:0] beat_data(input logic [127:0] b, input int k);
        return b ^ {4{32'(k)}};
    endfunction

    function automatic logic [15:0] beat_mask(input logic [127:0] b, input int k);
        return b[15:0] ^ 16'(k * 3);
    endfunction

    task automatic new_req(input int i);
        int sel;
        pend[i]    = 1'b1;
        r_cmd[i]   = 1'($urandom_range(0, 1));
        r_addr[i]  = AW'($urandom);
        sel        = $urandom_range(0, 9);
        r_burst[i] = (sel == 0) ? 6'd0 : (sel == 1) ? 6'd63 : 6'($urandom_range(1, 8));
        r_base[i]  = {$urandom, $urandom, $urandom, $urandom};
        r_wbeat[i] = 0;
    endtask

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_phase = 0; m_cmd = 0; m_addr = '0; m_burst = '0;
        m_base = '0; m_beat = 0; m_left = 0; m_err = 0; m_rdv = '0; m_rdd = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; r_gnt_seen[i] = 0; r_wbeat[i] = 0; r_cmd[i] = 0;
            r_addr[i] = '0; r_burst[i] = '0; r_base[i] = '0;
            m_ptxn[i] = 0; m_pwait[i] = 0;
        end
    endtask

    task automatic rst_check();
        chk("rst_gnt", O_gnt, 0);
        chk("rst_cmd_en", O_cmd_en, 0);
        chk("rst_cmd", O_cmd, 0);
        chk("rst_addr", O_addr, 0);
        chk("rst_burst", O_app_burst_number, 0);
        chk("rst_wr_en", O_wr_data_en, 0);
        chk("rst_wr_end", O_wr_data_end, 0);
        chk("rst_wr_data", O_wr_data, 0);
        chk("rst_wr_mask", O_wr_data_mask, 0);
        chk("rst_wr_ack", O_req_wr_ack, 0);
        chk("rst_rd_valid", O_req_rd_valid, 0);
        chk("rst_rd_data", O_rd_data, 0);
        chk("rst_err", O_err, 0);
        chk("rst_perf_txn", O_perf_txn, 0);
        chk("rst_perf_wait", O_perf_wait, 0);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && !r_gnt_seen[i] && $urandom_range(0, 99) < 30) new_req(i);
            I_req[i]               = pend[i];
            I_req_cmd[i]           = r_cmd[i];
            I_req_addr[i*AW +: AW] = r_addr[i];
            I_req_burst[i*6 +: 6]  = r_burst[i];
            I_req_wr_data[i*DW +: DW] = beat_data(r_base[i], r_wbeat[i]);
            I_req_wr_mask[i*MW +: MW] = beat_mask(r_base[i], r_wbeat[i]);
            I_req_wr_valid[i]      = ($urandom_range(0, 99) < 70);
        end
        I_init_calib_complete = !(cyc >= 1500 && cyc < 1600);
        I_cmd_ready     = ($urandom_range(0, 99) < 70);
        I_wr_data_rdy   = ($urandom_range(0, 1) == 1);
        I_rd_data_valid = (m_phase == 2 && m_cmd) ? ($urandom_range(0, 1) == 1) : 1'b0;
        I_rd_data_end   = 1'b0;
        I_rd_data       = {$urandom, $urandom, $urandom, $urandom};
        if (cyc >= 2500 && !err_injected && m_phase == 0) begin
            I_rd_data_valid = 1'b1;
            err_injected    = 1;
        end
    endtask

    task automatic check_update();
        logic [N-1:0] exp_gnt;
        bit           exp_wen;
        bit           done;
        int           w;
        exp_gnt = '0;
        if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
        exp_wen = (m_phase == 2) && !m_cmd && I_wr_data_rdy && I_req_wr_valid[m_owner];

        chk("gnt", O_gnt, exp_gnt);
        chk("cmd_en", O_cmd_en, (m_phase == 1) && I_cmd_ready);
        if (m_phase == 1) begin
            chk("cmd", O_cmd, m_cmd ? 3'b001 : 3'b000);
            chk("addr", O_addr, m_addr);
            chk("burst", O_app_burst_number, m_burst);
        end
        chk("wr_en", O_wr_data_en, exp_wen);
        chk("wr_ack", O_req_wr_ack, exp_wen ? exp_gnt : '0);
        chk("wr_end", O_wr_data_end, exp_wen && (m_left == 1));
        if (exp_wen) begin
            chk("wr_data", O_wr_data, beat_data(m_base, m_beat));
            chk("wr_mask", O_wr_data_mask, beat_mask(m_base, m_beat));
        end
        chk("rd_valid", O_req_rd_valid, m_rdv);
        chk("rd_data", O_rd_data, m_rdd);
        chk("err", O_err, m_err);
`ifdef DDR_ARB_PERF_CNT_EN
        for (int i = 0; i < N; i++) begin
            chk("perf_txn", O_perf_txn[i*32 +: 32], 32'(m_ptxn[i]));
            chk("perf_wait", O_perf_wait[i*32 +: 32], 32'(m_pwait[i]));
        end
`else
        chk("perf_txn", O_perf_txn, 0);
        chk("perf_wait", O_perf_wait, 0);
`endif

        // Predict the effect of the coming rising edge.
        m_rdv = (m_phase == 2 && m_cmd && I_rd_data_valid) ? exp_gnt : '0;
        m_rdd = I_rd_data;
        if (I_rd_data_valid && !(m_phase == 2 && m_cmd)) m_err = 1;
        for (int i = 0; i < N; i++)
            if (I_req[i] && !exp_gnt[i]) m_pwait[i]++;
        done = 0;
        case (m_phase)
            0: if (I_init_calib_complete && (I_req != '0)) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && I_req[(m_rr + k) % N]) w = (m_rr + k) % N;
                m_owner = w; m_rr = (w + 1) % N; m_phase = 1;
                m_cmd = r_cmd[w]; m_addr = r_addr[w]; m_burst = r_burst[w]; m_base = r_base[w];
                m_beat = 0; m_left = int'(r_burst[w]) + 1;
                n_txn++;
                $display("txn %0d cycle %0d: req%0d %s addr=%07h beats=%0d",
                         n_txn, cyc, w, m_cmd ? "read " : "write", m_addr, m_left);
            end
            1: if (I_cmd_ready) m_phase = 2;
            default: begin
                if (!m_cmd && exp_wen) begin
                    m_beat++; m_left--; done = (m_left == 0);
                end else if (m_cmd && I_rd_data_valid) begin
                    m_left--; done = (m_left == 0);
                end
            end
        endcase
        if (done) begin
            m_ptxn[m_owner]++;
            m_owner = -1;
            m_phase = 0;
        end

        // Requesters react to what the arbiter showed them.
        for (int i = 0; i < N; i++) begin
            if (O_gnt[i]) pend[i] = 0;
            r_gnt_seen[i] = O_gnt[i];
            if (O_req_wr_ack[i]) r_wbeat[i]++;
        end
    endtask

    initial begin
        I_rst_n = 1'b0; I_init_calib_complete = 1'b0; I_req = '0; I_req_cmd = '0;
        I_req_addr = '0; I_req_burst = '0; I_req_wr_data = '0; I_req_wr_mask = '0;
        I_req_wr_valid = '0; I_cmd_ready = 1'b0; I_wr_data_rdy = 1'b0;
        I_rd_data_valid = 1'b0; I_rd_data_end = 1'b0; I_rd_data = '0;
        model_reset();
        @(negedge clk);
        #2 rst_check();
        @(negedge clk);
        I_rst_n = 1'b1;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (!rst_done && ((cyc >= 1000 && m_phase == 2 && !m_cmd && m_beat >= 1) || cyc == 1400)) begin
                // Reset in the middle of a transaction, then both requesters
                // ask at once: requester 0 must win first.
                I_rst_n = 1'b0;
                #2 rst_check();
                repeat (2) @(negedge clk);
                model_reset();
                new_req(0);
                new_req(1);
                I_rst_n  = 1'b1;
                rst_done = 1;
            end
            drive_inputs();
            #2 check_update();
        end
        chk("err_sticky_end", O_err, m_err);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
